// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage data access block: a word-addressed data RAM plus a small
//   memory-mapped peripheral bus (interval timer with interrupt, free-running
//   systick, LED and digit-tube registers). Loads are combinational and
//   stores commit on the rising edge of clk.
//
// Ports
//   clk             system clock, all state updates on the rising edge
//   reset           synchronous active-low reset
//   MEM_MemRead     load enable
//   MEM_MemWrite    store enable
//   MEM_ALU_result  byte address (bits [1:0] ignored)
//   MEM_WriteData   store data
//   MEM_ReadData    load result, 0 when no load
//   leds            LED register
//   digits          digit-tube register: [11:8] anode select, [7:0] segments
//   irq             timer interrupt pending (TCON[2])
module mem_access_unit #(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [31:0] MEM_ALU_result,
  input  logic [31:0] MEM_WriteData,
  output logic [31:0] MEM_ReadData,
  output logic [7:0]  leds,
  output logic [11:0] digits,
  output logic        irq
);

  localparam int AW = $clog2(RAM_WORDS);

  // Peripheral word addresses (byte address >> 2)
  localparam logic [29:0] TH_W   = 30'h1000_0000;
  localparam logic [29:0] TL_W   = 30'h1000_0001;
  localparam logic [29:0] TCON_W = 30'h1000_0002;
  localparam logic [29:0] LED_W  = 30'h1000_0003;
  localparam logic [29:0] DIG_W  = 30'h1000_0004;
  localparam logic [29:0] TICK_W = 30'h1000_0005;

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;

  logic [29:0]   word_addr;
  logic          ram_hit;
  logic [AW-1:0] ram_idx;
  logic [31:0]   read_word;
  logic          unused_low_bits;

  assign word_addr       = MEM_ALU_result[31:2];
  assign ram_hit         = (MEM_ALU_result[31:AW+2] == '0);
  assign ram_idx         = MEM_ALU_result[AW+1:2];
  assign unused_low_bits = ^MEM_ALU_result[1:0];

  always_comb begin
    read_word = '0;
    if (ram_hit) begin
      read_word = ram[ram_idx];
    end else begin
      case (word_addr)
        TH_W:    read_word = th;
        TL_W:    read_word = tl;
        TCON_W:  read_word = {29'd0, tcon};
        LED_W:   read_word = {24'd0, leds};
        DIG_W:   read_word = {20'd0, digits};
        TICK_W:  read_word = systick;
        default: read_word = '0;
      endcase
    end
    MEM_ReadData = MEM_MemRead ? read_word : 32'd0;
  end

  // RAM is not cleared by reset, but a store in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset && MEM_MemWrite && ram_hit) begin
      ram[ram_idx] <= MEM_WriteData;
    end
  end

  // Timer tick/reload is scheduled first; a software write to the same
  // register later in the block overrides it for that register only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      leds    <= '0;
      digits  <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (tcon[0]) begin
        if (tl == 32'hFFFF_FFFF) begin
          tl <= th;
          if (tcon[1]) begin
            tcon[2] <= 1'b1;
          end
        end else begin
          tl <= tl + 32'd1;
        end
      end
      if (MEM_MemWrite && !ram_hit) begin
        case (word_addr)
          TH_W:    th     <= MEM_WriteData;
          TL_W:    tl     <= MEM_WriteData;
          TCON_W:  tcon   <= MEM_WriteData[2:0];
          LED_W:   leds   <= MEM_WriteData[7:0];
          DIG_W:   digits <= MEM_WriteData[11:0];
          default: ;
        endcase
      end
    end
  end

  assign irq = tcon[2];

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data access block of the pipeline, directly upstream of the MEM/WB register. It takes the address, store data and memory controls of the instruction in MEM and returns `MEM_ReadData` in the same cycle. It contains the data RAM and a memory-mapped peripheral bus: an interval timer with interrupt, a free-running systick counter, LED and digit-tube output registers.

## Interface
- `RAM_WORDS`, 256: data RAM depth in 32-bit words; power of two, at least 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`, effective when 0.
- `MEM_MemRead`  in  1  load enable for the instruction in MEM.
- `MEM_MemWrite`  in  1  store enable for the instruction in MEM.
- `MEM_ALU_result`  in  32  byte address of the access.
- `MEM_WriteData`  in  32  store data.
- `MEM_ReadData`  out  32  load result; feeds the MEM/WB register.
- `leds`  out  8  LED register.
- `digits`  out  12  digit-tube register: [11:8] anode select, [7:0] segments.
- `irq`  out  1  timer interrupt request; equals TCON[2].

## Operation
- Address decode uses `MEM_ALU_result`. Bits [1:0] are ignored, so all accesses are word accesses.
- Data RAM: byte addresses 0 to RAM_WORDS*4-1. Word index is addr[log2(RAM_WORDS)+1:2].
- Peripheral map:
  - 0x40000000 TH: timer reload value, R/W.
  - 0x40000004 TL: timer count, R/W.
  - 0x40000008 TCON, R/W, bits [2:0]: bit0 enable, bit1 irq enable, bit2 irq pending. Bits [31:3] read 0.
  - 0x4000000C LEDs: R/W, bits [7:0].
  - 0x40000010 digits: R/W, bits [11:0].
  - 0x40000014 systick: read-only; writes are ignored.
- Any other address: reads return 0, writes are ignored.
- Reads:
  - Combinational. `MEM_ReadData` is the decoded word when `MEM_MemRead`=1, otherwise 0.
  - Narrow registers are zero-extended.
- Writes: committed on the rising edge when `MEM_MemWrite`=1.
- If `MEM_MemRead` and `MEM_MemWrite` are both 1: the read returns the pre-write value and the write still commits.
- Timer: each cycle with TCON[0]=1:
  - If TL=0xFFFFFFFF: TL<=TH, and if TCON[1]=1 then TCON[2]<=1.
  - Otherwise TL<=TL+1. Arithmetic is 32-bit modulo.
- TCON[2] is cleared only by a software write of TCON with bit2=0, or by reset.
- Systick increments by 1 every cycle, including cycles with a bus access. It wraps from 0xFFFFFFFF to 0.
- Simultaneous events: a software write to TL, TH or TCON in the same cycle as a timer tick or reload takes priority for the written register. Registers that are not written still tick or reload.
  - Example: a write to TCON in an overflow cycle. TL still reloads. TCON takes the written value, so a pending bit being set that cycle is lost if the written bit2=0.

## Timing
- Reset, with `reset`=0 at a rising edge, clears TH, TL, TCON, LEDs, digits and systick to 0.
- Outputs after reset: `leds`=0, `digits`=0, `irq`=0.
- RAM contents are not cleared by reset.
- Reset overrides any store or tick in the same cycle.
- Load latency is 0 cycles: combinational from address and controls to `MEM_ReadData`.
- Store latency is 1 edge: a load of the same address in the next cycle returns the new value.
- `leds`, `digits` and `irq` are registered outputs. They change only on the rising edge.
- `irq` asserts on the edge where the overflow with irq enabled occurs.
- There is no stall or handshake: each access completes in its MEM cycle.

## Test plan
- Reset, then release: `leds`=0, `digits`=0, `irq`=0, and a read of systick one cycle after release returns 1.
- Store 0xDEADBEEF to addr 0x10, then load 0x10 next cycle -> 0xDEADBEEF. Load addr 0x13 -> 0xDEADBEEF.
- Load and store of addr 0x20 in the same cycle (old value 0x1, new value 0x2): `MEM_ReadData`=0x1 that cycle, 0x2 the next.
- Timer:
  - Stimulus: write TH=0xFFFFFFFC, TL=0xFFFFFFFE, TCON=3.
  - Required: TL reads 0xFFFFFFFF, then reloads to 0xFFFFFFFC with `irq`=1 on the second edge after the TCON write.
  - Then write TCON=3 -> `irq`=0 next cycle.
- Write TCON in the overflow cycle with data 0x3: TL reloads and `irq` stays 0.
- Unmapped address 0x50000000: load -> 0, store leaves all state unchanged. Store to systick is ignored and the count continues.
- Assert `reset` mid-run with timer enabled: all peripheral registers read 0 the next cycle, and RAM keeps previously stored data.
